// File: rtl/e_muldiv_pkg.sv
// Shared MIPS ALU function codes and multiply/divide FSM encoding.
// The ALU function decoder imports the same constants.
package e_muldiv_pkg;

    localparam logic [5:0] FN_MFHI  = 6'b010000;
    localparam logic [5:0] FN_MTHI  = 6'b010001;
    localparam logic [5:0] FN_MFLO  = 6'b010010;
    localparam logic [5:0] FN_MTLO  = 6'b010011;
    localparam logic [5:0] FN_MULT  = 6'b011000;
    localparam logic [5:0] FN_MULTU = 6'b011001;
    localparam logic [5:0] FN_DIV   = 6'b011010;
    localparam logic [5:0] FN_DIVU  = 6'b011011;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_MUL  = 2'd1;
    localparam logic [1:0] ST_DIV  = 2'd2;
    localparam logic [1:0] ST_FIX  = 2'd3;

    localparam logic [5:0] DIV_CYCLES = 6'd33;

    function automatic logic f_is_md_op(input logic [5:0] fn);
        logic r;
        case (fn)
            FN_MFHI, FN_MTHI, FN_MFLO, FN_MTLO,
            FN_MULT, FN_MULTU, FN_DIV, FN_DIVU: r = 1'b1;
            default:                            r = 1'b0;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/md_div_iter.sv
// Unsigned 32-bit restoring divider: loads on i_start, then one quotient bit per cycle.
// o_done is high for the cycle after the 32nd iteration, while results are held.
module md_div_iter (
    input  logic        clk,
    input  logic        reset,
    input  logic        i_start,
    input  logic [31:0] i_dividend,
    input  logic [31:0] i_divisor,
    output logic        o_done,
    output logic [31:0] o_quotient,
    output logic [31:0] o_remainder
);

    logic        r_busy;
    logic        r_done;
    logic [5:0]  r_cnt;
    logic [31:0] r_rem;
    logic [31:0] r_quo;
    logic [31:0] r_dsr;

    logic [32:0] w_shift;
    logic [32:0] w_diff;
    logic        w_fits;

    // Trial subtract on 33 bits so the borrow tells whether the divisor fits.
    assign w_shift = {r_rem, r_quo[31]};
    assign w_diff  = w_shift - {1'b0, r_dsr};
    assign w_fits  = ~w_diff[32];

    always_ff @(posedge clk) begin
        if (reset) begin
            r_busy <= 1'b0;
            r_done <= 1'b0;
            r_cnt  <= '0;
            r_rem  <= '0;
            r_quo  <= '0;
            r_dsr  <= '0;
        end else begin
            r_done <= 1'b0;
            if (i_start) begin
                r_busy <= 1'b1;
                r_cnt  <= 6'd32;
                r_rem  <= '0;
                r_quo  <= i_dividend;
                r_dsr  <= i_divisor;
            end else if (r_busy) begin
                r_rem <= w_fits ? w_diff[31:0] : w_shift[31:0];
                r_quo <= {r_quo[30:0], w_fits};
                r_cnt <= r_cnt - 6'd1;
                if (r_cnt == 6'd1) begin
                    r_busy <= 1'b0;
                    r_done <= 1'b1;
                end
            end
        end
    end

    assign o_done      = r_done;
    assign o_quotient  = r_quo;
    assign o_remainder = r_rem;

endmodule

// File: rtl/e_muldiv.sv
// E-stage multiply/divide unit: HI/LO registers, MFHI/MFLO/MTHI/MTLO, multi-cycle
// MULT/MULTU/DIV/DIVU, and the E-stage stall while an operation is in flight.
module e_muldiv
    import e_muldiv_pkg::*;
#(
    parameter int unsigned MULT_CYCLES = 5
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        E_valid,
    input  logic [5:0]  e_alufunc,
    input  logic [31:0] E_a,
    input  logic [31:0] E_b,
    output logic [31:0] e_mdout,
    output logic        e_mdstall,
    output logic [31:0] E_hi,
    output logic [31:0] E_lo,
    output logic        E_busy
);

    logic [1:0]  r_state;
    logic [5:0]  r_cnt;
    logic [31:0] r_hi;
    logic [31:0] r_lo;
    logic [63:0] r_prod;
    logic [31:0] r_dvd;
    logic        r_neg_q;
    logic        r_neg_r;
    logic        r_dz;

    logic        w_is_md;
    logic        w_accept;
    logic        w_signed;
    logic        w_is_mul;
    logic        w_is_div;
    logic [63:0] w_ext_a;
    logic [63:0] w_ext_b;
    logic [63:0] w_prod;
    logic [31:0] w_mag_a;
    logic [31:0] w_mag_b;
    logic        w_div_done;
    logic [31:0] w_quo;
    logic [31:0] w_rem;
    logic [31:0] w_quo_fix;
    logic [31:0] w_rem_fix;

    assign w_is_md  = f_is_md_op(e_alufunc);
    assign E_busy   = (r_state != ST_IDLE);
    assign w_accept = E_valid & w_is_md & ~E_busy;
    assign w_signed = ~e_alufunc[0];
    assign w_is_mul = (e_alufunc == FN_MULT) | (e_alufunc == FN_MULTU);
    assign w_is_div = (e_alufunc == FN_DIV) | (e_alufunc == FN_DIVU);

    assign w_ext_a = {{32{w_signed & E_a[31]}}, E_a};
    assign w_ext_b = {{32{w_signed & E_b[31]}}, E_b};
    assign w_prod  = w_ext_a * w_ext_b;

    assign w_mag_a = (w_signed & E_a[31]) ? (32'd0 - E_a) : E_a;
    assign w_mag_b = (w_signed & E_b[31]) ? (32'd0 - E_b) : E_b;

    md_div_iter u_div (
        .clk         (clk),
        .reset       (reset),
        .i_start     (w_accept & w_is_div),
        .i_dividend  (w_mag_a),
        .i_divisor   (w_mag_b),
        .o_done      (w_div_done),
        .o_quotient  (w_quo),
        .o_remainder (w_rem)
    );

    // Divide by zero bypasses sign fixup so signed and unsigned give the same answer.
    assign w_quo_fix = r_dz ? 32'hFFFF_FFFF : (r_neg_q ? (32'd0 - w_quo) : w_quo);
    assign w_rem_fix = r_dz ? r_dvd : (r_neg_r ? (32'd0 - w_rem) : w_rem);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
            r_hi    <= '0;
            r_lo    <= '0;
            r_prod  <= '0;
            r_dvd   <= '0;
            r_neg_q <= 1'b0;
            r_neg_r <= 1'b0;
            r_dz    <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_accept) begin
                        if (e_alufunc == FN_MTHI) r_hi <= E_a;
                        if (e_alufunc == FN_MTLO) r_lo <= E_a;
                        if (w_is_mul) begin
                            r_prod  <= w_prod;
                            r_cnt   <= 6'(MULT_CYCLES);
                            r_state <= ST_MUL;
                        end
                        if (w_is_div) begin
                            r_dvd   <= E_a;
                            r_neg_q <= w_signed & (E_a[31] ^ E_b[31]);
                            r_neg_r <= w_signed & E_a[31];
                            r_dz    <= (E_b == 32'd0);
                            r_cnt   <= DIV_CYCLES;
                            r_state <= ST_DIV;
                        end
                    end
                end
                ST_MUL: begin
                    r_cnt <= r_cnt - 6'd1;
                    if (r_cnt == 6'd1) begin
                        r_hi    <= r_prod[63:32];
                        r_lo    <= r_prod[31:0];
                        r_state <= ST_IDLE;
                    end
                end
                ST_DIV: begin
                    r_cnt <= r_cnt - 6'd1;
                    if (r_cnt == 6'd2) r_state <= ST_FIX;
                end
                ST_FIX: begin
                    if (w_div_done) begin
                        r_cnt   <= '0;
                        r_hi    <= w_rem_fix;
                        r_lo    <= w_quo_fix;
                        r_state <= ST_IDLE;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign E_hi      = r_hi;
    assign E_lo      = r_lo;
    assign e_mdstall = E_valid & w_is_md & E_busy;
    assign e_mdout   = (e_alufunc == FN_MFHI) ? r_hi :
                       (e_alufunc == FN_MFLO) ? r_lo : 32'd0;

endmodule
